dram_4x72: RTL and testbench

//   Small synchronous word-addressed storage array: 4 words x 72 bits.
//   One combined write/read-compare control selects write or read per cycle.

---
 rtl/dram_4x72.sv | 65 ++++++
 tb/tb_dram_4x72.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dram_4x72.sv
// 4 x 72-bit word store: one write or one registered read per clock, async active-low clear.
// Optional macro DRAM_WRITE_THROUGH_EN: a write also drives dataIN onto dataOUT on the same edge.

module dram_4x72_word #(
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= din;
  end

endmodule

module dram_4x72 #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIN,
  output logic [DATA_W-1:0] dataOUT,
  input  logic              Write_ReadCOMP
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] words;
  logic [DEPTH-1:0]             word_we;

  // One storage word per address; full binary decode, every code valid.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_we[i] = Write_ReadCOMP && (address == ADDR_W'(i));

    dram_4x72_word #(.DATA_W(DATA_W)) u_word (
      .clk   (clk),
      .reset (reset),
      .we    (word_we[i]),
      .din   (dataIN),
      .q     (words[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOUT <= '0;
    end else if (!Write_ReadCOMP) begin
      dataOUT <= words[address];
    end else begin
`ifdef DRAM_WRITE_THROUGH_EN
      dataOUT <= dataIN;
`else
      dataOUT <= dataOUT;
`endif
    end
  end

endmodule

// File: tb/tb_dram_4x72.sv
// Directed self-checking bench for dram_4x72 (both DRAM_WRITE_THROUGH_EN builds).

module tb_dram_4x72;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataIN;
  logic [DATA_W-1:0] dataOUT;
  logic              Write_ReadCOMP;

  int n_chk;
  int n_fail;
  logic [DATA_W-1:0] last_rd;

  dram_4x72 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .dataIN         (dataIN),
    .dataOUT        (dataOUT),
    .Write_ReadCOMP (Write_ReadCOMP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge and are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input string tag);
    logic [DATA_W-1:0] exp_out;
    address = a; dataIN = d; Write_ReadCOMP = 1'b1;
    tick();
`ifdef DRAM_WRITE_THROUGH_EN
    exp_out = d;
`else
    exp_out = last_rd;
`endif
    chk(tag, dataOUT, exp_out);
    last_rd = exp_out;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
    address = a; Write_ReadCOMP = 1'b0;
    tick();
    chk(tag, dataOUT, exp);
    last_rd = exp;
  endtask

  logic [DATA_W-1:0] v_aa, v_ff, v_hi, v_v, v_w;

  initial begin
    n_chk = 0; n_fail = 0; last_rd = '0;
    v_aa = {DATA_W{1'b0}}; v_aa = {36{2'b10}};
    v_ff = {DATA_W{1'b1}};
    v_hi = 72'h80_0000_0000_0000_0001;
    v_v  = 72'h12_3456_789A_BCDE_F012;
    v_w  = 72'hC3_5A5A_A5A5_0F0F_F0F0;

    // 1: reset with a write presented; it must be discarded.
    reset = 1'b0; address = 2'd1; dataIN = 72'h77; Write_ReadCOMP = 1'b1;
    tick(); tick();
    chk("rst_out", dataOUT, '0);
    reset = 1'b1;
    do_read(2'd0, '0, "rst_rd0");
    do_read(2'd1, '0, "rst_rd1");
    do_read(2'd2, '0, "rst_rd2");
    do_read(2'd3, '0, "rst_rd3");

    // 2
    do_write(2'd2, 72'd12, "wr2_hold");
    do_read(2'd2, 72'd12, "rd2_12");
    do_read(2'd0, '0, "rd0_zero");

    // 3: fill, then reverse readback
    do_write(2'd0, 72'h1, "wr0");
    do_write(2'd1, v_aa, "wr1");
    do_write(2'd2, v_ff, "wr2");
    do_write(2'd3, v_hi, "wr3");
    do_read(2'd3, v_hi, "rd3_hi");
    do_read(2'd2, v_ff, "rd2_ff");
    do_read(2'd1, v_aa, "rd1_aa");
    do_read(2'd0, 72'h1, "rd0_1");
    do_read(2'd3, v_hi, "rd3_again");

    // 4: reset asserted between edges clears immediately
    do_write(2'd1, 72'd5, "wr1_5");
    #3 reset = 1'b0;
    #1 chk("midrst_out", dataOUT, '0);
    tick(); tick();
    chk("midrst_hold", dataOUT, '0);
    reset = 1'b1; last_rd = '0;
    do_read(2'd1, '0, "midrst_rd1");
    do_read(2'd3, '0, "midrst_rd3");

    // 5: write-through behaviour
    do_write(2'd3, v_v, "wr3_v");
    do_read(2'd3, v_v, "rd3_v");
    do_write(2'd3, v_w, "wr3_w_out");
    do_read(2'd3, v_w, "rd3_w");

    // 6: read held with dataIN=12 must not disturb memory
    address = 2'd3; dataIN = 72'd12; Write_ReadCOMP = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rd3", dataOUT, v_w);
    end
    do_read(2'd2, '0, "hold_rd2");
    do_read(2'd3, v_w, "hold_rd3_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
